// File: rtl/bus_wr_arb_pkg.sv
// Shared bus definitions: default widths and requester count for the write
// bus, plus the arbitration pointer width derived from the requester count.
package bus_wr_arb_pkg;

  localparam int BUS_N      = 4;
  localparam int BUS_ADDR_W = 13;
  localparam int BUS_DATA_W = 9;

  // A pointer over n requesters needs clog2(n) bits, but never fewer than one.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BUS_PTR_W = ptr_width(BUS_N);

endpackage

// File: rtl/bus_wr_arb_rr_pick.sv
// Combinational round-robin picker: finds the first set request strictly after
// ptr, wrapping, and reports it as an index and as a one-hot vector.
module rr_pick
  import bus_wr_arb_pkg::*;
#(
  parameter int N  = BUS_N,
  parameter int PW = ptr_width(BUS_N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          any,
  output logic [PW-1:0] grant_idx,
  output logic [N-1:0]  grant_oh
);

  int idx;

  // NOTE: every output gets a default before the search loop; a path that
  // skips an assignment in always_comb would otherwise infer a latch.
  always_comb begin
    any       = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any       = 1'b1;
        grant_idx = PW'(idx);
      end
    end
    grant_oh = any ? (N'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/bus_wr_arb.sv
// N-to-1 write-bus arbiter: round-robin selection into a single output
// register that drives the shared bus, with full-throughput backpressure.
module bus_wr_arb
  import bus_wr_arb_pkg::*;
#(
  parameter int N      = BUS_N,
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N*ADDR_W-1:0] m_wraddr,
  input  logic [N*DATA_W-1:0] m_wrdata,
  input  logic [N-1:0]        m_wrvalid,
  output logic [N-1:0]        m_wrready,
  output logic [ADDR_W-1:0]   bus_wraddr,
  output logic [DATA_W-1:0]   bus_wrdata,
  output logic                bus_wrvalid,
  input  logic                bus_wrready
);

  localparam int PW = ptr_width(N);

  logic [PW-1:0]     ptr;
  logic              load;
  logic              any;
  logic [PW-1:0]     grant_idx;
  logic [N-1:0]      grant_oh;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_rr_pick (
    .req       (m_wrvalid),
    .ptr       (ptr),
    .any       (any),
    .grant_idx (grant_idx),
    .grant_oh  (grant_oh)
  );

  // The register may accept a new write when empty or when it drains this cycle.
  assign load      = !bus_wrvalid || bus_wrready;
  assign m_wrready = load ? grant_oh : '0;
  assign sel_addr  = m_wraddr[int'(grant_idx)*ADDR_W +: ADDR_W];
  assign sel_data  = m_wrdata[int'(grant_idx)*DATA_W +: DATA_W];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_wrvalid <= 1'b0;
      bus_wraddr  <= '0;
      bus_wrdata  <= '0;
      ptr         <= PW'(N - 1);
    end else if (load) begin
      if (any) begin
        bus_wrvalid <= 1'b1;
        bus_wraddr  <= sel_addr;
        bus_wrdata  <= sel_data;
        ptr         <= grant_idx;
      end else begin
        bus_wrvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_wr_arb.sv
// Directed bench for bus_wr_arb: hand-computed vector table plus short
// sequences for reset, mid-transaction reset and a lone requester.
module tb_bus_wr_arb;

  localparam int N      = 4;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 9;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N*ADDR_W-1:0] m_wraddr = '0;
  logic [N*DATA_W-1:0] m_wrdata = '0;
  logic [N-1:0]        m_wrvalid = '0;
  logic [N-1:0]        m_wrready;
  logic [ADDR_W-1:0]   bus_wraddr;
  logic [DATA_W-1:0]   bus_wrdata;
  logic                bus_wrvalid;
  logic                bus_wrready = 1'b0;

  int tests = 0;
  int fails = 0;

  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;

  always #5 clk = ~clk;

  bus_wr_arb #(
    .N      (N),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m_wraddr    (m_wraddr),
    .m_wrdata    (m_wrdata),
    .m_wrvalid   (m_wrvalid),
    .m_wrready   (m_wrready),
    .bus_wraddr  (bus_wraddr),
    .bus_wrdata  (bus_wrdata),
    .bus_wrvalid (bus_wrvalid),
    .bus_wrready (bus_wrready)
  );

  typedef struct {
    logic [N-1:0] valid;
    logic         ready;
    logic [N-1:0] exp_rdy;
    logic         exp_bv;
    int           gnt;     // requester expected in OREG after the edge, -1 = hold
  } vec_t;

  vec_t tbl[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Requester i in step v offers addr v*16+i and data 0x0A5+v*8+i.
  function automatic logic [ADDR_W-1:0] addr_of(input int v, input int i);
    return ADDR_W'(v * 16 + i);
  endfunction

  function automatic logic [DATA_W-1:0] data_of(input int v, input int i);
    return DATA_W'(9'h0A5 + v * 8 + i);
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic apply(input vec_t t, input int v, input string name);
    for (int i = 0; i < N; i++) begin
      m_wraddr[i*ADDR_W +: ADDR_W] = addr_of(v, i);
      m_wrdata[i*DATA_W +: DATA_W] = data_of(v, i);
    end
    m_wrvalid   = t.valid;
    bus_wrready = t.ready;
    #1;
    check({name, ".m_wrready"}, 32'(m_wrready), 32'(t.exp_rdy));
    @(posedge clk);
    #1;
    if (t.gnt >= 0) begin
      exp_addr = addr_of(v, t.gnt);
      exp_data = data_of(v, t.gnt);
    end
    check({name, ".bus_wrvalid"}, 32'(bus_wrvalid), 32'(t.exp_bv));
    check({name, ".bus_wraddr"}, 32'(bus_wraddr), 32'(exp_addr));
    check({name, ".bus_wrdata"}, 32'(bus_wrdata), 32'(exp_data));
    @(negedge clk);
  endtask

  task automatic do_reset(input string name);
    rst_n       = 1'b0;
    m_wrvalid   = '0;
    bus_wrready = 1'b0;
    #2;
    check({name, ".bus_wrvalid"}, 32'(bus_wrvalid), 32'd0);
    check({name, ".bus_wraddr"}, 32'(bus_wraddr), 32'd0);
    check({name, ".bus_wrdata"}, 32'(bus_wrdata), 32'd0);
    check({name, ".m_wrready"}, 32'(m_wrready), 32'd0);
    exp_addr = '0;
    exp_data = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic [N-1:0] valid, input logic ready,
                              input logic [N-1:0] exp_rdy, input logic exp_bv,
                              input int gnt);
    vec_t t;
    t.valid   = valid;
    t.ready   = ready;
    t.exp_rdy = exp_rdy;
    t.exp_bv  = exp_bv;
    t.gnt     = gnt;
    return t;
  endfunction

  initial begin
    // Table assumes a fresh reset: ptr = 3, OREG empty.
    for (int k = 0; k < 8; k++)
      tbl[k] = mk(4'b1111, 1'b1, 4'(1 << (k % 4)), 1'b1, k % 4);
    tbl[8]  = mk(4'b0000, 1'b1, 4'b0000, 1'b0, -1);  // drain, data holds
    tbl[9]  = mk(4'b0011, 1'b1, 4'b0001, 1'b1, 0);
    tbl[10] = mk(4'b0011, 1'b1, 4'b0010, 1'b1, 1);
    tbl[11] = mk(4'b0100, 1'b1, 4'b0100, 1'b1, 2);
    tbl[12] = mk(4'b0011, 1'b1, 4'b0001, 1'b1, 0);   // ptr=2 wraps to 0
    tbl[13] = mk(4'b0110, 1'b0, 4'b0000, 1'b1, -1);  // stall x3
    tbl[14] = mk(4'b0110, 1'b0, 4'b0000, 1'b1, -1);
    tbl[15] = mk(4'b0110, 1'b0, 4'b0000, 1'b1, -1);
    tbl[16] = mk(4'b0110, 1'b1, 4'b0010, 1'b1, 1);
    tbl[17] = mk(4'b1000, 1'b1, 4'b1000, 1'b1, 3);
    tbl[18] = mk(4'b1000, 1'b0, 4'b0000, 1'b1, -1);
    tbl[19] = mk(4'b0000, 1'b1, 4'b0000, 1'b0, -1);
    tbl[20] = mk(4'b0000, 1'b0, 4'b0000, 1'b0, -1);
    tbl[21] = mk(4'b0101, 1'b0, 4'b0001, 1'b1, 0);   // empty OREG loads despite ready=0

    do_reset("reset0");

    // First write after reset: requester 0, addr 0, data 0x0A5.
    apply(mk(4'b0001, 1'b1, 4'b0001, 1'b1, 0), 0, "first");
    apply(mk(4'b0000, 1'b1, 4'b0000, 1'b0, -1), 1, "first_drain");

    do_reset("reset1");
    for (int k = 0; k < 22; k++)
      apply(tbl[k], k, $sformatf("vec%0d", k));

    // Lone requester 2: consecutive grants, valid falls one cycle after it drops.
    do_reset("reset2");
    for (int k = 0; k < 5; k++)
      apply(mk(4'b0100, 1'b1, 4'b0100, 1'b1, 2), 30 + k, $sformatf("solo%0d", k));
    apply(mk(4'b0000, 1'b1, 4'b0000, 1'b0, -1), 35, "solo_end");

    // Asynchronous reset during a stalled bus write.
    do_reset("reset3");
    apply(mk(4'b0001, 1'b1, 4'b0001, 1'b1, 0), 40, "pre_abort");
    bus_wrready = 1'b0;
    m_wrvalid   = '0;
    #2;
    rst_n = 1'b0;
    #1;
    check("abort.bus_wrvalid", 32'(bus_wrvalid), 32'd0);
    check("abort.bus_wraddr", 32'(bus_wraddr), 32'd0);
    check("abort.bus_wrdata", 32'(bus_wrdata), 32'd0);
    exp_addr = '0;
    exp_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(4'b0000, 1'b0, 4'b0000, 1'b0, -1), 41, "post_abort0");
    apply(mk(4'b0000, 1'b1, 4'b0000, 1'b0, -1), 42, "post_abort1");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_wr_arb.md
BUS_WR_ARB -- requirements
Module: bus_wr_arb

Interface
REQ-001 Parameter N, default 4, SHALL set the number of write requesters (2..8).
REQ-002 Parameter ADDR_W, default 13, SHALL set the write-address width.
REQ-003 Parameter DATA_W, default 9, SHALL set the write-data width.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 m_wraddr  input  N*ADDR_W  SHALL carry requester i's address in bits [i*ADDR_W +: ADDR_W].
REQ-007 m_wrdata  input  N*DATA_W  SHALL carry requester i's data in bits [i*DATA_W +: DATA_W].
REQ-008 m_wrvalid  input  N  SHALL be requester i's write request, bit i.
REQ-009 m_wrready  output  N  SHALL be the per-requester acceptance, bit i.
REQ-010 bus_wraddr  output  ADDR_W  SHALL be the shared-bus write address.
REQ-011 bus_wrdata  output  DATA_W  SHALL be the shared-bus write data.
REQ-012 bus_wrvalid  output  1  SHALL be the shared-bus write valid.
REQ-013 bus_wrready  input  1  SHALL be the shared-bus write ready from the addressed peripheral.

Function
REQ-014 A write SHALL transfer on a port in any cycle where its valid and ready are both high.
REQ-015 The block SHALL contain one output register (OREG) holding bus_wraddr, bus_wrdata and bus_wrvalid; bus outputs SHALL come only from OREG.
REQ-016 load = !bus_wrvalid || bus_wrready; OREG SHALL load exactly in cycles where load is high and any m_wrvalid bit is high.
REQ-017 On load, the granted requester g SHALL be the first set m_wrvalid bit searching from (ptr+1) mod N upward, wrapping.
REQ-018 m_wrready[i] SHALL be high only when load is high and i == g; at most one bit high per cycle. It may depend combinationally on m_wrvalid.
REQ-019 On load, OREG SHALL capture requester g's address and data, set bus_wrvalid=1, and set ptr=g.
REQ-020 When load is high and no m_wrvalid bit is set, bus_wrvalid SHALL go to 0 next cycle. Address and data hold their values.
REQ-021 While bus_wrvalid=1 and bus_wrready=0, OREG and ptr SHALL hold; all m_wrready bits SHALL be 0.
REQ-022 Latency SHALL be one cycle from requester handshake to bus_wrvalid. Sustained throughput SHALL be one write per cycle when bus_wrready stays high.
REQ-023 Fairness: with all N requesters continuously valid, grants SHALL rotate 0,1,...,N-1,0 with no requester granted twice before every other requester is granted once.
REQ-024 A requester deasserting m_wrvalid before its handshake SHALL simply drop out of arbitration; no state records it.

Reset
REQ-025 While rst_n=0: bus_wrvalid=0, bus_wraddr=0, bus_wrdata=0, ptr=N-1 (requester 0 wins first), m_wrready=0.
REQ-026 Reset asserted mid-transaction SHALL discard the OREG contents; the pending bus write is abandoned and not replayed.
REQ-027 After rst_n deassertion, the first load SHALL occur no earlier than the first rising edge with rst_n=1.

Structure
REQ-028 ADDR_W, DATA_W, N defaults and the ptr width (clog2 N) SHALL live in the shared bus definitions package/include used by bus peripherals.
REQ-029 The round-robin search SHALL be a sub-module rr_pick (inputs: req[N], ptr; outputs: any, grant index, one-hot grant), purely combinational.
REQ-030 bus_wr_arb SHALL contain only OREG, ptr and the load logic around rr_pick.

Verification
REQ-031 Reset, then m_wrvalid=0001, addr 0, data 0x0A5, bus_wrready=1 -> m_wrready=0001 same cycle; next cycle bus_wrvalid=1, addr 0, data 0x0A5.
REQ-032 m_wrvalid=1111 held 8 cycles, bus_wrready=1 -> grant order 0,1,2,3,0,1,2,3, one bus write per cycle.
REQ-033 bus_wrready=0 for 3 cycles with OREG full and m_wrvalid=0110 -> bus outputs stable, m_wrready=0000; on bus_wrready=1 the next write goes to requester 1 in the same cycle.
REQ-034 ptr=2, m_wrvalid=0011 -> grant 0 (wrap past 3).
REQ-035 rst_n pulsed low while bus_wrvalid=1 and bus_wrready=0 -> bus_wrvalid=0 immediately (asynchronous); no write of the old data after release.
REQ-036 Single requester 2 valid for 5 cycles, bus_wrready=1 -> 5 consecutive grants to 2; bus_wrvalid falls the cycle after m_wrvalid drops.
